// File: rtl/lcd_timed_port_if.sv
// rtl/lcd_timed_port_if.sv - Avalon-style register bus between a master and lcd_timed_port
interface lcd_timed_port_if;
  logic [1:0] address;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       waitrequest;

  modport master (output address, read, write, writedata, input readdata, waitrequest);
  modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/lcd_timed_port.sv
// rtl/lcd_timed_port.sv - HD44780-style LCD bus timing engine behind an Avalon slave
module lcd_timed_port #(
  parameter int DATA_WIDTH = 8,
  parameter int T_SETUP    = 2,
  parameter int T_EN       = 12,
  parameter int T_HOLD     = 2,
  parameter int T_GAP      = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  lcd_timed_port_if.slave       bus,
  output logic                  LCD_E,
  output logic                  LCD_RS,
  output logic                  LCD_RW,
  output logic [DATA_WIDTH-1:0] LCD_data_out,
  output logic                  LCD_data_oe,
  input  logic [DATA_WIDTH-1:0] LCD_data_in
);
  localparam int  T_MAX_A = (T_SETUP > T_EN) ? T_SETUP : T_EN;
  localparam int  T_MAX_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
  localparam int  T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int  CW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam bit  NIBBLE  = (DATA_WIDTH == 4);

  if (DATA_WIDTH != 4 && DATA_WIDTH != 8) begin : g_bad_width
    $error("lcd_timed_port: DATA_WIDTH must be 4 or 8");
  end

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_GAP, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rs_q, rs_d, rw_q, rw_d, lo_q, lo_d;
  logic [7:0]            byte_q, byte_d, rdata_q, rdata_d;
  logic                  e_q, e_d, pin_rs_q, pin_rs_d, pin_rw_q, pin_rw_d, oe_q, oe_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [7:0]            din8, sel_byte;
  logic                  active;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    lo_d    = lo_q;
    byte_d  = byte_q;
    rdata_d = rdata_q;
    din8    = 8'(LCD_data_in);
    case (state_q)
      S_IDLE: begin
        if (bus.read || bus.write) begin
          rs_d    = bus.address[1];
          // a simultaneous write wins over read
          rw_d    = bus.address[0] & ~bus.write;
          byte_d  = bus.writedata;
          lo_d    = 1'b0;
          cnt_d   = CW'(T_SETUP - 1);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_ENABLE;
          cnt_d   = CW'(T_EN - 1);
        end else cnt_d = cnt_q - CW'(1);
      end
      S_ENABLE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CW'(T_HOLD - 1);
          if (rw_q) begin
            if (!NIBBLE)   rdata_d      = din8;
            else if (lo_q) rdata_d[3:0] = din8[3:0];
            else           rdata_d[7:4] = din8[3:0];
          end
        end else cnt_d = cnt_q - CW'(1);
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (NIBBLE && !lo_q) begin
            state_d = S_GAP;
            cnt_d   = CW'(T_GAP - 1);
          end else state_d = S_DONE;
        end else cnt_d = cnt_q - CW'(1);
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_SETUP;
          cnt_d   = CW'(T_SETUP - 1);
          lo_d    = 1'b1;
        end else cnt_d = cnt_q - CW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // pins are registered from the next state so they line up with the state itself
    active   = (state_d == S_SETUP) || (state_d == S_ENABLE) || (state_d == S_HOLD);
    sel_byte = (NIBBLE && !lo_d) ? {4'b0, byte_d[7:4]} : byte_d;
    e_d      = (state_d == S_ENABLE);
    pin_rs_d = active & rs_d;
    pin_rw_d = active & rw_d;
    oe_d     = active & ~rw_d;
    dout_d   = (active && !rw_d) ? sel_byte[DATA_WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      lo_q     <= 1'b0;
      byte_q   <= '0;
      rdata_q  <= '0;
      e_q      <= 1'b0;
      pin_rs_q <= 1'b0;
      pin_rw_q <= 1'b0;
      oe_q     <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs_q     <= rs_d;
      rw_q     <= rw_d;
      lo_q     <= lo_d;
      byte_q   <= byte_d;
      rdata_q  <= rdata_d;
      e_q      <= e_d;
      pin_rs_q <= pin_rs_d;
      pin_rw_q <= pin_rw_d;
      oe_q     <= oe_d;
      dout_q   <= dout_d;
    end
  end

  assign bus.waitrequest = (bus.read | bus.write) & (state_q != S_DONE);
  assign bus.readdata    = rdata_q;
  assign LCD_E           = e_q;
  assign LCD_RS          = pin_rs_q;
  assign LCD_RW          = pin_rw_q;
  assign LCD_data_oe     = oe_q;
  assign LCD_data_out    = dout_q;
endmodule

// File: doc/lcd_timed_port.md
LCD_TIMED_PORT -- requirements
Module: lcd_timed_port

Interface
Parameters (name, default, meaning):
REQ-001 DATA_WIDTH, 8, LCD bus width; legal values 4 or 8 only.
REQ-002 T_SETUP, 2, clk cycles RS/RW/data stable before LCD_E rises; legal range >=1.
REQ-003 T_EN, 12, clk cycles LCD_E held high; legal range >=1.
REQ-004 T_HOLD, 2, clk cycles RS/RW/data held after LCD_E falls; legal range >=1.
REQ-005 T_GAP, 24, clk cycles with LCD_E low between the two nibbles in 4-bit mode; legal range >=1; unused when DATA_WIDTH=8.
Ports (name, direction, width, meaning):
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 address  in  2  bit0 = RW (1=read), bit1 = RS (1=data register).
REQ-009 read  in  1  Avalon read request; held by the master while waitrequest=1.
REQ-010 write  in  1  Avalon write request; held by the master while waitrequest=1.
REQ-011 writedata  in  8  byte to send to the LCD.
REQ-012 readdata  out  8  byte read from the LCD; valid in the cycle waitrequest falls.
REQ-013 waitrequest  out  1  stall to the master.
REQ-014 LCD_E, LCD_RS, LCD_RW  out  1 each  LCD control pins, all registered.
REQ-015 LCD_data_out  out  DATA_WIDTH  registered bus drive value.
REQ-016 LCD_data_oe  out  1  bus output enable; the top level builds the tristate.
REQ-017 LCD_data_in  in  DATA_WIDTH  bus sample value.

Function
REQ-018 The FSM states SHALL be IDLE, SETUP, ENABLE, HOLD, GAP, DONE; one down-counter, loaded with T_x-1 on entry, times each timed state.
REQ-019 IDLE: when read or write is 1, the block latches RS=address[1], RW=address[0] and writedata, then enters SETUP.
REQ-020 Transitions:
- SETUP->ENABLE at count 0.
- ENABLE->HOLD at count 0.
- HOLD->DONE at count 0, or HOLD->GAP when the high nibble has just completed in 4-bit mode.
- GAP->SETUP at count 0, low nibble selected.
- DONE->IDLE unconditionally.
REQ-021 waitrequest SHALL equal (read|write) & (state!=DONE); it is combinational and low for exactly one cycle per transfer.
REQ-022 LCD_RS/LCD_RW SHALL hold the latched values from SETUP through HOLD; LCD_E=1 only in ENABLE.
REQ-023 Writes (RW=0): LCD_data_oe=1 from SETUP through HOLD.
- 8-bit mode: LCD_data_out = latched byte.
- 4-bit mode: LCD_data_out = latched byte [7:4] on the first pulse, then [3:0] on the second.
REQ-024 Reads (RW=1): LCD_data_oe=0 throughout; LCD_data_in is sampled on the last ENABLE cycle into readdata ([7:4] then [3:0] in 4-bit mode); readdata holds until the next read completes.
REQ-025 Latency in 8-bit mode, from the first request cycle to the waitrequest-low cycle: 1+T_SETUP+T_EN+T_HOLD cycles.
REQ-026 Latency in 4-bit mode: 1+2*(T_SETUP+T_EN+T_HOLD)+T_GAP cycles.
REQ-027 read and write both 1 in IDLE SHALL be treated as a write.
REQ-028 Request changes after acceptance SHALL be ignored until DONE.
REQ-029 In DONE, a request still asserted is not re-accepted; IDLE in the following cycle accepts a new one, so back-to-back transfers are separated by one IDLE cycle.
REQ-030 Counter width SHALL be sized for max(T_SETUP, T_EN, T_HOLD, T_GAP)-1 with no wrap.
REQ-031 DATA_WIDTH values other than 4 or 8 SHALL raise an elaboration error.

Reset
REQ-032 While reset=1, at the next clk edge: state=IDLE; LCD_E, LCD_RS, LCD_RW, LCD_data_oe = 0; LCD_data_out, readdata and the counter = 0.
REQ-033 Reset asserted mid-transfer SHALL abort it: LCD_E low and the bus released on the next edge, and no second nibble is issued.

Verification
REQ-034 8-bit write, defaults, address=2'b10, writedata=0x41 -> RS=1, RW=0, data=0x41, oe=1; E high exactly 12 cycles, after 2 setup cycles; waitrequest low in cycle 17.
REQ-035 DATA_WIDTH=4 write of 0x28 to address 0 -> two E pulses with data 0x2 then 0x8, separated by 24 E-low gap cycles; total latency 57 cycles.
REQ-036 8-bit read from address 2'b01, LCD_data_in=0x80 during ENABLE -> oe=0 throughout; readdata=0x80 in the waitrequest-low cycle.
REQ-037 write and read held high together, 3 back-to-back requests -> each is treated as a write, each has its own DONE, and exactly one IDLE cycle separates transfers.
REQ-038 reset pulsed during the ENABLE of the first nibble (4-bit) -> E=0 and oe=0 next cycle, no second pulse, and a new write completes normally.
REQ-039 T_SETUP=T_EN=T_HOLD=1, 8-bit -> waitrequest low in cycle 4 and E high exactly 1 cycle.
